// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencer with a one-entry output slot, branch redirect and halt detection
module instruction_fetch #(
  parameter int MEM_DEPTH = 64,
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  output logic [7:0] instruction_address,
  input  logic [7:0] instruction_data,
  output logic [7:0] out_instr,
  output logic [7:0] out_pc,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       halted
);
  localparam logic [7:0] PC_MASK = 8'(MEM_DEPTH - 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
  state_t state_q, state_d;
  logic [7:0] pc_q, pc_d, instr_q, instr_d, opc_q, opc_d;
  logic valid_q, valid_d, halted_q;
  logic slot_free;
  assign slot_free = !valid_q || out_ready;
  assign instruction_address = pc_q;
  assign out_instr = instr_q;
  assign out_pc = opc_q;
  assign out_valid = valid_q;
  assign halted = halted_q;
  // next state: a redirect wins over everything; otherwise capture in RUN when the slot is free
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    opc_d = opc_q;
    valid_d = valid_q && !out_ready;
    if (branch_taken) begin
      state_d = S_RUN;
      pc_d = branch_target & PC_MASK;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = start ? S_RUN : S_IDLE;
        S_RUN: if (slot_free) begin
          instr_d = instruction_data;
          opc_d = pc_q;
          valid_d = 1'b1;
          state_d = (instruction_data == HALT_OPCODE) ? S_HALT : S_RUN;
          pc_d = (instruction_data == HALT_OPCODE) ? pc_q : ((pc_q + 8'd1) & PC_MASK);
        end
        S_HALT: if (start) begin
          state_d = S_RUN;
          pc_d = (pc_q + 8'd1) & PC_MASK;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  // state registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q <= RESET_PC;
      instr_q <= 8'h00;
      opc_q <= 8'h00;
      valid_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      opc_q <= opc_d;
      valid_q <= valid_d;
      halted_q <= (state_d == S_HALT);
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of streaming, stall, redirect, wrap/halt and async reset
module tb_instruction_fetch;
  logic clk, rst_n, start, branch_taken, out_ready, out_valid, halted;
  logic [7:0] branch_target, instruction_address, instruction_data, out_instr, out_pc;
  logic [7:0] mem [64];
  int n_chk = 0, n_err = 0;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .branch_taken(branch_taken),
    .branch_target(branch_target), .instruction_address(instruction_address),
    .instruction_data(instruction_data), .out_instr(out_instr), .out_pc(out_pc),
    .out_valid(out_valid), .out_ready(out_ready), .halted(halted)
  );

  assign instruction_data = mem[instruction_address[5:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [7:0] pc, input logic [7:0] ins);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, out_instr, ins);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h10 + 8'(i);
    mem[63] = 8'hFF;
    rst_n = 1'b0; start = 1'b0; branch_taken = 1'b0; branch_target = 8'h00; out_ready = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr", instruction_address, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_wait", out_valid, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_no_capture", out_valid, 0);
    tick();
    beat("stream0", 8'h00, 8'h10);
    chk("stream0_addr", instruction_address, 1);
    for (int p = 1; p <= 5; p++) begin
      tick();
      beat("stream", 8'(p), 8'h10 + 8'(p));
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      beat("stall", 8'h05, 8'h15);
      chk("stall_addr", instruction_address, 6);
    end
    out_ready = 1'b1;
    tick();
    beat("unstall", 8'h06, 8'h16);
    start = 1'b1;
    tick();
    start = 1'b0;
    beat("start_in_run", 8'h07, 8'h17);
    branch_taken = 1'b1; branch_target = 8'h03;
    tick();
    branch_taken = 1'b0;
    chk("br3_flush", out_valid, 0);
    chk("br3_addr", instruction_address, 3);
    tick();
    beat("br3_beat", 8'h03, 8'h13);
    out_ready = 1'b0;
    tick();
    beat("br3_stall", 8'h03, 8'h13);
    branch_taken = 1'b1; branch_target = 8'h2A;
    tick();
    branch_taken = 1'b0; out_ready = 1'b1;
    chk("br2a_flush", out_valid, 0);
    chk("br2a_addr", instruction_address, 8'h2A);
    tick();
    beat("br2a_beat", 8'h2A, 8'h3A);
    branch_taken = 1'b1; branch_target = 8'h45;
    tick();
    branch_taken = 1'b0;
    chk("br45_flush", out_valid, 0);
    chk("br45_addr", instruction_address, 8'h05);
    tick();
    beat("br45_beat", 8'h05, 8'h15);
    branch_taken = 1'b1; branch_target = 8'h3E;
    tick();
    branch_taken = 1'b0;
    chk("br3e_flush", out_valid, 0);
    tick();
    beat("wrap62", 8'h3E, 8'h4E);
    chk("wrap62_halted", halted, 0);
    tick();
    beat("halt63", 8'h3F, 8'hFF);
    chk("halt63_halted", halted, 1);
    chk("halt63_addr", instruction_address, 8'h3F);
    out_ready = 1'b0;
    tick();
    beat("halt_pending", 8'h3F, 8'hFF);
    out_ready = 1'b1;
    tick();
    chk("halt_drained", out_valid, 0);
    chk("halt_still", halted, 1);
    tick();
    chk("halt_no_capture", out_valid, 0);
    chk("halt_addr_hold", instruction_address, 8'h3F);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("resume_halted", halted, 0);
    chk("resume_valid", out_valid, 0);
    chk("resume_addr", instruction_address, 0);
    tick();
    beat("resume_beat", 8'h00, 8'h10);
    tick();
    beat("pre_reset", 8'h01, 8'h11);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_pc", out_pc, 0);
    chk("async_instr", out_instr, 0);
    chk("async_halted", halted, 0);
    chk("async_addr", instruction_address, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_idle", out_valid, 0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_no_capture", out_valid, 0);
    tick();
    beat("restart_beat", 8'h00, 8'h10);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter MEM_DEPTH, default 64, SHALL set the instruction-memory word count; PC wraps modulo MEM_DEPTH (power of two, ≤256).
REQ-002 Parameter RESET_PC, default 8'h00, SHALL set the PC value loaded at reset.
REQ-003 Parameter HALT_OPCODE, default 8'hFF, SHALL set the instruction word that stops fetching.
REQ-004 One clock and one reset: reset is asynchronous and active-low; the clock port is clk and the reset port is rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  leave IDLE or HALT and begin fetching at the current PC.
REQ-008 branch_taken  input  1  redirect request from execute; highest priority.
REQ-009 branch_target  input  8  redirect address; used modulo MEM_DEPTH.
REQ-010 instruction_address  output  8  combinational read address to instruction memory, always equal to PC.
REQ-011 instruction_data  input  8  combinational read data from instruction memory for instruction_address.
REQ-012 out_instr  output  8  registered instruction word for decode.
REQ-013 out_pc  output  8  address out_instr was fetched from.
REQ-014 out_valid  output  1  out_instr/out_pc hold a valid instruction.
REQ-015 out_ready  input  1  decode accepts the instruction this cycle.
REQ-016 halted  output  1  high while the FSM is in HALT.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN, and HALT.
REQ-018 The output slot SHALL be "free" when out_valid=0 or out_ready=1.
REQ-019 In RUN with the slot free and no redirect, one clk edge SHALL perform out_instr<=instruction_data, out_pc<=PC, out_valid<=1, and PC<=(PC+1) mod MEM_DEPTH.
REQ-020 In RUN with out_valid=1 and out_ready=0 (stall), PC, out_instr, out_pc, and out_valid SHALL hold unchanged.
REQ-021 PC wrap: PC=MEM_DEPTH-1 SHALL advance to 0.
REQ-022 branch_taken=1 in any state SHALL, at that edge, set PC<=branch_target mod MEM_DEPTH, set out_valid<=0 (flushing any held instruction, even if stalled or simultaneously accepted), and enter RUN; no instruction SHALL be captured that edge.
REQ-023 After a redirect, the target instruction SHALL appear with out_valid=1 exactly one cycle later if decode is not stalling.
REQ-024 In IDLE, start=1 SHALL move the FSM to RUN without capturing; the first capture SHALL occur on the next edge, giving out_valid=1 two edges after start is sampled.
REQ-025 Capturing a word equal to HALT_OPCODE SHALL deliver it normally (out_valid=1), leave PC pointing at the halt word (no increment), and enter HALT.
REQ-026 In HALT, no capture SHALL occur; the pending out_valid SHALL remain until consumed by out_ready, then drop to 0.
REQ-027 start in HALT SHALL set PC<=(PC+1) mod MEM_DEPTH and enter RUN; a simultaneous branch_taken SHALL override it per REQ-022.
REQ-028 start SHALL be ignored in RUN.
REQ-029 halted SHALL be a registered state decode, with 1 only in HALT.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock edge, set: FSM=IDLE, PC=RESET_PC, out_valid=0, out_instr=8'h00, out_pc=8'h00, halted=0.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; after release, the block SHALL wait in IDLE for start.
REQ-032 Release of rst_n SHALL take effect synchronously; the first edge with rst_n=1 SHALL be treated as normal IDLE operation.

Verification
REQ-033 Streaming: memory holds i->8'h10+i, start, out_ready=1 -> consecutive out_pc 0,1,2,... with out_instr 10,11,12,..., and the first valid appears 2 edges after start.
REQ-034 Stall: hold out_ready=0 for 3 cycles at out_pc=5 -> out_instr/out_pc/instruction_address frozen at 5/5/6; on release, the next beat is pc 6 with no duplicate or skip.
REQ-035 Redirect: branch_taken with target 8'h2A while stalled at pc 3 -> out_valid=0 next cycle; the following beat is out_pc=8'h2A (MEM_DEPTH=64 gives 0x2A), and target 8'h45 maps to 8'h05.
REQ-036 Wrap/halt: run from pc 62, word 63=8'hFF -> beats 62,63, halted=1, no further valid; start -> beat from pc 0.
REQ-037 Reset: assert rst_n=0 asynchronously between edges during streaming -> outputs reach their reset values before the next edge; no valid appears until start is reasserted.
